// File: rtl/aes_pkg.sv
// AES-128 shared FSM type, block/schedule constants and byte-level helpers
// used by the iterative round controller and its combinational round.
package aes_pkg;

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_ROUND, S_FINAL, S_DONE} state_t;

  localparam int NR      = 10;
  localparam int BLOCK_W = 128;
  localparam int SCHED_W = 1408;

  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; a[31:24] is the row-0 byte.
  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [0:BLOCK_W-1] rk(input logic [0:SCHED_W-1] sched, input logic [3:0] r);
    return sched[{r, 7'b0000000} +: BLOCK_W];
  endfunction

endpackage

// File: rtl/aes_round.sv
// Combinational AES round: SubBytes, ShiftRows, MixColumns (skipped when
// i_final is set) and AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  logic [0:BLOCK_W-1] i_state,
  input  logic [0:BLOCK_W-1] i_rkey,
  input  logic               i_final,
  output logic [0:BLOCK_W-1] o_state
);

  logic [0:BLOCK_W-1] w_sb;
  logic [0:BLOCK_W-1] w_sr;
  logic [0:BLOCK_W-1] w_mc;

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign w_sb[8*i +: 8] = sbox(i_state[8*i +: 8]);
  end

  // Byte index is 4*column + row; row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign w_sr[8*(4*c+r) +: 8] = w_sb[8*(4*((c+r)%4)+r) +: 8];
    end
    assign w_mc[32*c +: 32] = mix_col(w_sr[32*c +: 32]);
  end

  assign o_state = (i_final ? w_sr : w_mc) ^ i_rkey;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption controller: 11 edges from accept to out_valid.
// Define AES_ROUND_CTRL_ABORT_EN to add an abort input for in-flight blocks.
module aes_round_ctrl #(
  parameter int NR = aes_pkg::NR
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [0:aes_pkg::BLOCK_W-1]   in_msg,
  input  logic [0:aes_pkg::BLOCK_W-1]   in_key,
  output logic [0:aes_pkg::BLOCK_W-1]   key_out,
  input  logic [0:aes_pkg::SCHED_W-1]   key_schedule,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [0:aes_pkg::BLOCK_W-1]   out_cipher,
  output logic                          busy,
  output logic [3:0]                    round_o
`ifdef AES_ROUND_CTRL_ABORT_EN
  ,
  input  logic                          abort
`endif
);

  aes_pkg::state_t                r_fsm;
  aes_pkg::state_t                w_fsm_nxt;
  logic [0:aes_pkg::BLOCK_W-1]    r_state;
  logic [0:aes_pkg::BLOCK_W-1]    r_key;
  logic [0:aes_pkg::BLOCK_W-1]    w_state_nxt;
  logic [0:aes_pkg::BLOCK_W-1]    w_rkey;
  logic [0:aes_pkg::BLOCK_W-1]    w_round_out;
  logic [3:0]                     r_round;
  logic [3:0]                     w_round_nxt;
  logic                           w_state_ld;
  logic                           w_key_ld;
  logic                           w_abort;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_rkey = aes_pkg::rk(key_schedule, r_round);

  aes_round u_round (
    .i_state (r_state),
    .i_rkey  (w_rkey),
    .i_final (r_fsm == aes_pkg::S_FINAL),
    .o_state (w_round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= aes_pkg::S_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_ld  = 1'b0;
    w_state_nxt = r_state;
    w_key_ld    = 1'b0;
    w_round_nxt = r_round;
    unique case (r_fsm)
      aes_pkg::S_IDLE: begin
        if (in_valid) begin
          w_fsm_nxt   = aes_pkg::S_INIT;
          w_state_ld  = 1'b1;
          w_state_nxt = in_msg;
          w_key_ld    = 1'b1;
          w_round_nxt = 4'd0;
        end
      end
      aes_pkg::S_INIT: begin
        w_fsm_nxt   = aes_pkg::S_ROUND;
        w_state_ld  = 1'b1;
        w_state_nxt = r_state ^ w_rkey;
        w_round_nxt = 4'd1;
      end
      aes_pkg::S_ROUND: begin
        w_state_ld  = 1'b1;
        w_state_nxt = w_round_out;
        w_round_nxt = r_round + 4'd1;
        if (r_round == 4'(NR - 1)) begin
          w_fsm_nxt = aes_pkg::S_FINAL;
        end
      end
      aes_pkg::S_FINAL: begin
        w_fsm_nxt   = aes_pkg::S_DONE;
        w_state_ld  = 1'b1;
        w_state_nxt = w_round_out;
      end
      aes_pkg::S_DONE: begin
        if (out_ready) begin
          w_fsm_nxt   = aes_pkg::S_IDLE;
          w_round_nxt = 4'd0;
        end
      end
      default: begin
        w_fsm_nxt   = aes_pkg::S_IDLE;
        w_round_nxt = 4'd0;
      end
    endcase
    // Abort leaves state and key untouched so the last block stays inspectable.
    if (w_abort && (r_fsm == aes_pkg::S_INIT || r_fsm == aes_pkg::S_ROUND ||
                    r_fsm == aes_pkg::S_FINAL)) begin
      w_fsm_nxt   = aes_pkg::S_IDLE;
      w_state_ld  = 1'b0;
      w_round_nxt = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_key   <= '0;
      r_round <= 4'd0;
    end else begin
      if (w_state_ld) begin
        r_state <= w_state_nxt;
      end
      if (w_key_ld) begin
        r_key <= in_key;
      end
      r_round <= w_round_nxt;
    end
  end

  assign in_ready   = (r_fsm == aes_pkg::S_IDLE);
  assign busy       = (r_fsm != aes_pkg::S_IDLE);
  assign out_valid  = (r_fsm == aes_pkg::S_DONE);
  assign out_cipher = r_state;
  assign key_out    = r_key;
  assign round_o    = r_round;

endmodule
